// File: rtl/piano_voice.sv
// piano_voice: single-voice square-wave tone generator; the lowest-index pressed key sets the pitch.
// Release sustain stage is compiled in with `define PIANO_SUSTAIN_EN (default build: no sustain).
module piano_voice #(
    parameter int unsigned                NUM_KEYS       = 8,
    parameter int unsigned                DIV_W          = 20,
    parameter logic [NUM_KEYS*DIV_W-1:0]  HALF_PERIODS   = {20'd95556,  20'd101239, 20'd113636, 20'd127551,
                                                            20'd143173, 20'd151686, 20'd170262, 20'd191113},
    parameter int unsigned                SUSTAIN_CYCLES = 25_000_000,
    parameter int unsigned                SUS_W          = 25
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [NUM_KEYS-1:0]         KEYS,
    input  logic [1:0]                  OCTAVE,
    output logic                        FREQ,
    output logic                        ACTIVE,
    output logic [$clog2(NUM_KEYS)-1:0] NOTE
);
    localparam int unsigned NOTE_W = $clog2(NUM_KEYS);

    if (NUM_KEYS < 2 || DIV_W < 1 || SUS_W < 1 || SUS_W > 32 || SUSTAIN_CYCLES < 1 ||
        64'(SUSTAIN_CYCLES) > (64'd1 << SUS_W)) begin : g_bad_cfg
        $error("piano_voice: invalid parameter set");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1,
        SUSTAIN = 2'd2
    } state_e;

    state_e              state_q;
    logic [NUM_KEYS-1:0] sync1_q;
    logic [NUM_KEYS-1:0] sync2_q;
    logic [DIV_W-1:0]    cur_h_q;
    logic [DIV_W-1:0]    cnt_q;
    logic                freq_q;
    logic                active_q;
    logic [NOTE_W-1:0]   note_q;
`ifdef PIANO_SUSTAIN_EN
    logic [SUS_W-1:0]    sus_q;
`endif

    logic                any_c;
    logic [NOTE_W-1:0]   sel_c;
    logic [DIV_W-1:0]    base_h_c;
    logic [DIV_W-1:0]    shift_h_c;
    logic [DIV_W-1:0]    eff_h_c;
    logic                toggle_c;
    logic [DIV_W-1:0]    cnt_step_c;

    // Key levels are asynchronous: two-flop synchroniser.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= KEYS;
            sync2_q <= sync1_q;
        end
    end

    // Lowest-index pressed key wins; scan downwards so the last hit is the lowest.
    always_comb begin
        sel_c    = '0;
        base_h_c = HALF_PERIODS[DIV_W-1:0];
        for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
            if (sync2_q[i]) begin
                sel_c    = NOTE_W'(i);
                base_h_c = HALF_PERIODS[i*DIV_W +: DIV_W];
            end
        end
    end

    assign any_c      = |sync2_q;
    assign shift_h_c  = base_h_c >> OCTAVE;
    assign eff_h_c    = (shift_h_c == '0) ? DIV_W'(1) : shift_h_c;
    assign toggle_c   = (cnt_q == cur_h_q - DIV_W'(1));
    assign cnt_step_c = toggle_c ? '0 : cnt_q + DIV_W'(1);

    // Voice FSM; pitch reloads only at a FREQ toggle so half periods are never cut short.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= IDLE;
            freq_q   <= 1'b0;
            active_q <= 1'b0;
            note_q   <= '0;
            cnt_q    <= '0;
            cur_h_q  <= '0;
`ifdef PIANO_SUSTAIN_EN
            sus_q    <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    freq_q <= 1'b0;
                    cnt_q  <= '0;
                    if (any_c) begin
                        state_q  <= PLAY;
                        active_q <= 1'b1;
                        cur_h_q  <= eff_h_c;
                        note_q   <= sel_c;
                    end
                end
                PLAY: begin
`ifdef PIANO_SUSTAIN_EN
                    cnt_q <= cnt_step_c;
                    if (toggle_c) begin
                        freq_q <= ~freq_q;
                        if (any_c) begin
                            cur_h_q <= eff_h_c;
                            note_q  <= sel_c;
                        end
                    end
                    if (!any_c) begin
                        state_q <= SUSTAIN;
                        sus_q   <= '0;
                    end
`else
                    if (!any_c) begin
                        state_q  <= IDLE;
                        active_q <= 1'b0;
                        freq_q   <= 1'b0;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_step_c;
                        if (toggle_c) begin
                            freq_q  <= ~freq_q;
                            cur_h_q <= eff_h_c;
                            note_q  <= sel_c;
                        end
                    end
`endif
                end
`ifdef PIANO_SUSTAIN_EN
                SUSTAIN: begin
                    if (!any_c && sus_q == SUS_W'(SUSTAIN_CYCLES - 1)) begin
                        state_q  <= IDLE;
                        active_q <= 1'b0;
                        freq_q   <= 1'b0;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_step_c;
                        sus_q <= sus_q + SUS_W'(1);
                        if (toggle_c) begin
                            freq_q <= ~freq_q;
                        end
                        if (any_c) begin
                            state_q <= PLAY;
                        end
                    end
                end
`endif
                default: begin
                    state_q  <= IDLE;
                    active_q <= 1'b0;
                    freq_q   <= 1'b0;
                    cnt_q    <= '0;
                end
            endcase
        end
    end

    assign FREQ   = freq_q;
    assign ACTIVE = active_q;
    assign NOTE   = note_q;

endmodule

// File: tb/tb_piano_voice.sv
// Bench for piano_voice: event-level voice model compared every cycle, plus hand-timed checks.
// Two instances: normal half-period table and one with a zero slice for key 0 (clamp case).
module tb_piano_voice;
    localparam int NK  = 4;
    localparam int SUS = 50;
`ifdef PIANO_SUSTAIN_EN
    localparam bit SUS_ON = 1'b1;
`else
    localparam bit SUS_ON = 1'b0;
`endif
    localparam int M_OFF  = 0;
    localparam int M_HELD = 1;
    localparam int M_RING = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [NK-1:0] keys;
    logic [1:0]    oct;
    logic          freq_a, act_a, freq_z, act_z;
    logic [1:0]    note_a, note_z;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    int hp [2][NK] = '{'{4, 6, 8, 10}, '{0, 6, 8, 10}};
    int m_mode [2];
    int m_lvl  [2];
    int m_el   [2];
    int m_half [2];
    int m_note [2];
    int m_ring [2];
    logic [NK-1:0] m_s1 = '0;
    logic [NK-1:0] m_s2 = '0;

    piano_voice #(
        .NUM_KEYS(NK), .DIV_W(8), .HALF_PERIODS({8'd10, 8'd8, 8'd6, 8'd4}),
        .SUSTAIN_CYCLES(SUS), .SUS_W(6)
    ) u_a (
        .CLK(clk), .RESET(rst), .KEYS(keys), .OCTAVE(oct),
        .FREQ(freq_a), .ACTIVE(act_a), .NOTE(note_a)
    );

    piano_voice #(
        .NUM_KEYS(NK), .DIV_W(8), .HALF_PERIODS({8'd10, 8'd8, 8'd6, 8'd0}),
        .SUSTAIN_CYCLES(SUS), .SUS_W(6)
    ) u_z (
        .CLK(clk), .RESET(rst), .KEYS(keys), .OCTAVE(oct),
        .FREQ(freq_z), .ACTIVE(act_z), .NOTE(note_z)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int lowest(input logic [NK-1:0] k);
        for (int i = 0; i < NK; i++) begin
            if (k[i]) return i;
        end
        return 0;
    endfunction

    // One clock of a voice: tone runs in half periods of m_half cycles; pitch only adopted at an edge.
    task automatic model_step(input int i, input logic [NK-1:0] k, input int o);
        bit pr;
        int lo;
        int want;
        pr   = (k != '0);
        lo   = lowest(k);
        want = hp[i][lo] >> o;
        if (want == 0) want = 1;
        if (m_mode[i] == M_OFF) begin
            if (pr) begin
                m_mode[i] = M_HELD;
                m_half[i] = want;
                m_note[i] = lo;
                m_el[i]   = 0;
                m_lvl[i]  = 0;
            end
        end else if (!pr && ((m_mode[i] == M_HELD && !SUS_ON) ||
                             (m_mode[i] == M_RING && m_ring[i] == SUS - 1))) begin
            m_mode[i] = M_OFF;
            m_lvl[i]  = 0;
        end else begin
            m_el[i]++;
            if (m_el[i] == m_half[i]) begin
                m_el[i]  = 0;
                m_lvl[i] = 1 - m_lvl[i];
                if (m_mode[i] == M_HELD && pr) begin
                    m_half[i] = want;
                    m_note[i] = lo;
                end
            end
            if (m_mode[i] == M_HELD && !pr) begin
                m_mode[i] = M_RING;
                m_ring[i] = 0;
            end else if (m_mode[i] == M_RING) begin
                if (pr) m_mode[i] = M_HELD;
                else    m_ring[i]++;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_mode[i] = M_OFF; m_lvl[i] = 0; m_el[i] = 0;
                m_half[i] = 0; m_note[i] = 0; m_ring[i] = 0;
            end
            m_s1 = '0;
            m_s2 = '0;
        end else begin
            for (int i = 0; i < 2; i++) model_step(i, m_s2, int'(oct));
            m_s2 = m_s1;
            m_s1 = keys;
        end
    end

    // Every-cycle comparison of both instances against the model.
    initial forever begin
        @(posedge clk);
        #2;
        if (chk_en && !rst) begin
            check($sformatf("a.freq@%0d", cyc), int'(freq_a), m_lvl[0]);
            check($sformatf("a.active@%0d", cyc), int'(act_a), int'(m_mode[0] != M_OFF));
            check($sformatf("a.note@%0d", cyc), int'(note_a), m_note[0]);
            check($sformatf("z.freq@%0d", cyc), int'(freq_z), m_lvl[1]);
            check($sformatf("z.active@%0d", cyc), int'(act_z), int'(m_mode[1] != M_OFF));
            check($sformatf("z.note@%0d", cyc), int'(note_z), m_note[1]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int j = 0; j < n; j++) tick();
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        keys = '0;
        oct  = 2'd0;
        ticks(2);
        rst  = 1'b0;
    endtask

    task automatic wait_tog(output int at);
        logic prev;
        prev = freq_a;
        at   = -1000;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (freq_a !== prev) begin
                at = cyc;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL tog_timeout: no FREQ edge within 100 cycles (cyc %0d)", cyc);
    endtask

    initial begin
        int t1, t2, t3, t4, c0, z;
        rst  = 1'b1;
        keys = '0;
        oct  = 2'd0;
        ticks(3);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Idle after reset
        z = 0;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (freq_a || act_a || note_a != 2'd0) z++;
        end
        check("idle_quiet_100", z, 0);

        // Key 2: latency, note, period 16 with 50% duty
        keys = 4'b0100;
        tick(); check("act_k0", int'(act_a), 0);
        tick(); check("act_k1", int'(act_a), 0);
        tick(); check("act_k2", int'(act_a), 1);
        check("note_key2", int'(note_a), 2);
        check("freq_start_low", int'(freq_a), 0);
        c0 = cyc;
        wait_tog(t1);
        check("first_rise_delay", t1 - c0, 8);
        check("first_rise_level", int'(freq_a), 1);
        wait_tog(t2);
        check("high_width", t2 - t1, 8);
        wait_tog(t3);
        check("period", t3 - t1, 16);

        // Note change mid half period: old half completes, then new pitch
        do_reset();
        keys = 4'b0110;
        ticks(3);
        check("note_key1", int'(note_a), 1);
        wait_tog(t1);
        ticks(2);
        keys = 4'b0101;
        ticks(3);
        check("note_hold_until_edge", int'(note_a), 1);
        wait_tog(t2);
        check("old_half_completes", t2 - t1, 6);
        check("note_switch_at_edge", int'(note_a), 0);
        wait_tog(t3);
        check("new_half_1", t3 - t2, 4);
        wait_tog(t4);
        check("new_half_2", t4 - t3, 4);

        // Octave shift down to H = 1
        do_reset();
        oct  = 2'd3;
        keys = 4'b1000;
        ticks(3);
        check("note_key3", int'(note_a), 3);
        wait_tog(t1);
        wait_tog(t2);
        wait_tog(t3);
        check("oct3_half_a", t2 - t1, 1);
        check("oct3_half_b", t3 - t2, 1);

        // Zero slice clamps to H = 1
        do_reset();
        keys = 4'b0001;
        ticks(3);
        check("clamp_active", int'(act_z), 1);
        tick(); check("clamp_f1", int'(freq_z), 1);
        tick(); check("clamp_f2", int'(freq_z), 0);
        tick(); check("clamp_f3", int'(freq_z), 1);
        tick(); check("key0_rise_at_4", int'(freq_a), 1);

        // Release
        keys = 4'b0000;
        tick(); check("rel_act_k0", int'(act_a), 1);
        tick(); check("rel_act_k1", int'(act_a), 1);
        tick();
`ifdef PIANO_SUSTAIN_EN
        check("sus_entry_active", int'(act_a), 1);
        ticks(49);
        check("sus_still_active", int'(act_a), 1);
        tick();
        check("sus_end_active", int'(act_a), 0);
        check("sus_end_freq", int'(freq_a), 0);

        // Re-press 30 cycles into sustain: no gap
        do_reset();
        keys = 4'b0100;
        ticks(20);
        keys = 4'b0000;
        ticks(3);
        ticks(29);
        keys = 4'b0100;
        z = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (!act_a) z++;
        end
        check("repress_no_gap", z, 0);
        check("repress_note", int'(note_a), 2);
`else
        check("rel_act_k2", int'(act_a), 0);
        check("rel_freq_k2", int'(freq_a), 0);
`endif

        // Asynchronous reset mid-tone, then restart from IDLE with key held
        do_reset();
        keys = 4'b0010;
        ticks(10);
        check("pre_rst_note", int'(note_a), 1);
        #4 rst = 1'b1;
        #1;
        check("rst_freq_a", int'(freq_a), 0);
        check("rst_act_a", int'(act_a), 0);
        check("rst_note_a", int'(note_a), 0);
        check("rst_act_z", int'(act_z), 0);
        check("rst_note_z", int'(note_z), 0);
        @(posedge clk);
        #1;
        tick();
        rst = 1'b0;
        tick(); check("restart_k0", int'(act_a), 0);
        tick(); check("restart_k1", int'(act_a), 0);
        tick(); check("restart_k2", int'(act_a), 1);
        check("restart_note", int'(note_a), 1);

`ifdef PIANO_SUSTAIN_EN
        // Asynchronous reset mid-sustain
        keys = 4'b0000;
        ticks(13);
        check("mid_sus_active", int'(act_a), 1);
        #4 rst = 1'b1;
        #1;
        check("rst_sus_act", int'(act_a), 0);
        check("rst_sus_freq", int'(freq_a), 0);
        check("rst_sus_note", int'(note_a), 0);
        @(posedge clk);
        #1;
        tick();
        rst = 1'b0;
        ticks(3);
        check("post_sus_rst_idle", int'(act_a), 0);
`endif

        ticks(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/piano_voice.md
# piano_voice

Parametrised single-voice square-wave tone generator for the FPGA piano. It replaces fixed per-note clock outputs and a switch priority mux with one programmable half-period divider. The block takes a bank of key inputs, selects the lowest-index pressed key, applies an octave shift and drives a glitch-free square wave on `FREQ` for the speaker/PMOD pin. An optional sustain stage keeps the last note sounding for a fixed time after release.

## Interface
- `NUM_KEYS`, 8, number of key inputs (≥2).
- `DIV_W`, 20, width of half-period values and the divider counter.
- `HALF_PERIODS`, {95556,101239,113636,127551,143173,151686,170262,191113}, packed `NUM_KEYS*DIV_W`. Key i uses slice i (C4..C5 at 100 MHz, key 0 = C4 in LSB slice).
- `SUSTAIN_CYCLES`, 25_000_000, release hold time in clocks.
- `SUS_W`, 25, sustain counter width.

Ports:
- `CLK` in 1: system clock.
- `RESET` in 1: asynchronous, active-high reset.
- `KEYS` in NUM_KEYS: asynchronous key/switch levels, 1 = pressed.
- `OCTAVE` in 2: right-shift applied to half period (0 = base, 3 = +3 octaves). Sampled synchronously.
- `FREQ` out 1: square-wave tone.
- `ACTIVE` out 1: high whenever state ≠ IDLE.
- `NOTE` out clog2(NUM_KEYS): index of the note currently driving the divider.

## Operation
- `KEYS` pass through a 2-flop synchroniser. Selection `sel` = lowest set bit index of the synchronised keys. `any` = OR of the synchronised keys.
- Effective half period `H = HALF_PERIODS[sel] >> OCTAVE`. If the result is 0, H = 1.
- Registers hold `cur_h` (DIV_W) and `cnt` (DIV_W).
- States: IDLE, PLAY, SUSTAIN.
  - IDLE: `FREQ` = 0, `cnt` = 0. If `any`, go to PLAY, load `cur_h` = H, set `NOTE` = `sel`, `cnt` = 0.
  - PLAY: divider runs. If not `any`, go to SUSTAIN, or to IDLE when sustain is compiled out.
  - SUSTAIN: divider keeps running on `cur_h`/`NOTE`, and the sustain counter increments. If `any`, go to PLAY. When the count reaches `SUSTAIN_CYCLES-1`, go to IDLE and clear `FREQ`.
- Divider in PLAY/SUSTAIN:
  - While `cnt` < `cur_h-1`, `cnt` increments.
  - When `cnt == cur_h-1`, `FREQ` toggles and `cnt` returns to 0. On that same edge `cur_h` and `NOTE` reload from the current H/`sel`, but only in PLAY.
- Note and octave changes therefore take effect only at a `FREQ` edge, so there are no runt pulses.
- Entry to IDLE from PLAY/SUSTAIN forces `FREQ` low on the transition edge, even mid-half-period.
- The sustain counter clears on every entry to SUSTAIN.
- Reset values: state IDLE, `FREQ` 0, `ACTIVE` 0, `NOTE` 0, `cnt` 0, `cur_h` 0, synchronisers 0, sustain counter 0.

## Timing
- A key change sampled at edge k reaches `sync2` after edge k+1. The state/`ACTIVE` update happens at edge k+2.
- First `FREQ` rise occurs `cur_h` cycles after entering PLAY.
- Period = 2·`cur_h` cycles exactly.
- Release is detected at edge k+2 (same path). With sustain, `FREQ` drops `SUSTAIN_CYCLES` cycles after SUSTAIN entry.
- Key change while playing: the new pitch starts at the next `FREQ` toggle. The in-progress half period always completes at the old value.
- Simultaneous toggle and release on the same edge: release wins. State moves to SUSTAIN/IDLE, and `cur_h` is not reloaded.
- Asynchronous `RESET` mid-tone immediately forces all outputs to reset values.

## Configuration
- `PIANO_SUSTAIN_EN` defined: SUSTAIN state and sustain counter are compiled in, behaving as above.
- `PIANO_SUSTAIN_EN` undefined: no SUSTAIN state and no counter. PLAY goes directly to IDLE on release, and `FREQ` clears on that edge. `SUSTAIN_CYCLES`/`SUS_W` are ignored.

## Test plan
Bench parameters: NUM_KEYS=4, DIV_W=8, HALF_PERIODS={4,6,8,10} (key0 = 4), SUSTAIN_CYCLES=50.
- Reset released, `KEYS`=0: `FREQ`=0, `ACTIVE`=0, `NOTE`=0 held for 100 cycles.
- `KEYS`=4'b0100, `OCTAVE`=0:
  - `ACTIVE` rises 2 edges after the sampling edge.
  - `NOTE`=2.
  - `FREQ` period 16 cycles, 50% duty.
- `KEYS`=4'b0110 → 4'b0101 mid-half-period:
  - `NOTE` goes 1→0 only at the next `FREQ` toggle.
  - Half periods go 6 then 4, with no pulse shorter than 4.
- `KEYS`=4'b1000, `OCTAVE`=3: H = 10>>3 = 1, so `FREQ` toggles every cycle. With `OCTAVE`=0 and `HALF_PERIODS` slice 0 = 0 (separate build), H clamps to 1.
- Release with `PIANO_SUSTAIN_EN`:
  - Tone continues for exactly 50 cycles, then `FREQ`=0 and `ACTIVE`=0.
  - A re-press at cycle 30 of sustain returns to PLAY with no gap.
  - Without the macro, `FREQ`/`ACTIVE` drop 2 edges after release.
- Assert `RESET` mid-tone and mid-sustain: all outputs 0 immediately. After deassert with a key held, the state restarts from IDLE.
